gpio_ctrl: RTL

GPIO_CTRL -- requirements
Module: gpio_ctrl

---
 rtl/gpio_ctrl_pkg.sv | 20 ++
 rtl/gpio_ctrl_sync.sv | 38 +++
 rtl/gpio_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/gpio_ctrl_pkg.sv
// GPIO controller shared definitions: base address, register offsets
// and the byte-enable expansion helper.
package gpio_ctrl_pkg;

    localparam logic [31:0] GPIO_ADDR = 32'h4000_0000;

    localparam logic [4:0] GPIO_OUT_OFS      = 5'h00;
    localparam logic [4:0] GPIO_OE_OFS       = 5'h04;
    localparam logic [4:0] GPIO_IN_OFS       = 5'h08;
    localparam logic [4:0] GPIO_SET_OFS      = 5'h0C;
    localparam logic [4:0] GPIO_CLR_OFS      = 5'h10;
    localparam logic [4:0] GPIO_IRQ_EN_OFS   = 5'h14;
    localparam logic [4:0] GPIO_IRQ_STAT_OFS = 5'h18;
    localparam logic [4:0] GPIO_IRQ_EDGE_OFS = 5'h1C;

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/gpio_ctrl_sync.sv
// gpio_sync: 2-flop input synchronizer, one-cycle delay copy and
// registered rise/fall pulses (pulse appears one edge after the delay compare).
module gpio_sync #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] dly;

    // synchronizer chain, delayed copy and edge pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= RST_VAL;
            s2   <= RST_VAL;
            dly  <= RST_VAL;
            rise <= '0;
            fall <= '0;
        end else begin
            s1   <= d;
            s2   <= s1;
            dly  <= s2;
            rise <= s2 & ~dly;
            fall <= ~s2 & dly;
        end
    end

    assign q = s2;

endmodule

// File: rtl/gpio_ctrl.sv
// GPIO controller top: OUT/OE/IN/SET/CLR registers, optional edge
// interrupts enabled by defining GPIO_IRQ_EN.
module gpio_ctrl
    import gpio_ctrl_pkg::*;
#(
    parameter int          WIDTH    = 8,
    parameter logic [31:0] IN_RESET = 32'h0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic             re,
    input  logic [4:0]       addr,
    input  logic [3:0]       be,
    input  logic [31:0]      wr_data,
    output logic [31:0]      rd_data,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    localparam logic [WIDTH-1:0] IN_RST = IN_RESET[WIDTH-1:0];

    logic [4:0]       ofs;
    logic [31:0]      mask32;
    logic [WIDTH-1:0] wm;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] oe_q;
    logic [WIDTH-1:0] in_sync;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [31:0]      rd_next;
    logic             unused_bits;

    assign ofs    = {addr[4:2], 2'b00};
    assign mask32 = be_mask(be);
    assign wm     = mask32[WIDTH-1:0];
    assign wd     = wr_data[WIDTH-1:0];

    gpio_sync #(
        .WIDTH   (WIDTH),
        .RST_VAL (IN_RST)
    ) u_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (gpio_in),
        .q    (in_sync),
        .rise (rise),
        .fall (fall)
    );

    // OUT / OE updates, including byte-gated set and clear aliases
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= '0;
            oe_q  <= '0;
        end else if (we) begin
            case (ofs)
                GPIO_OUT_OFS: out_q <= (out_q & ~wm) | (wd & wm);
                GPIO_OE_OFS:  oe_q  <= (oe_q & ~wm) | (wd & wm);
                GPIO_SET_OFS: out_q <= out_q | (wd & wm);
                GPIO_CLR_OFS: out_q <= out_q & ~(wd & wm);
                default: ;
            endcase
        end
    end

`ifdef GPIO_IRQ_EN
    logic [WIDTH-1:0] en_q;
    logic [WIDTH-1:0] st_q;
    logic [WIDTH-1:0] pol_q;
    logic [WIDTH-1:0] hit;
    logic [WIDTH-1:0] w1c;

    assign hit = (rise & ~pol_q) | (fall & pol_q);
    assign w1c = (we && ofs == GPIO_IRQ_STAT_OFS) ? (wd & wm) : '0;

    // interrupt registers; a new edge beats a same-cycle clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q  <= '0;
            st_q  <= '0;
            pol_q <= '0;
        end else begin
            st_q <= (st_q & ~w1c) | hit;
            if (we && ofs == GPIO_IRQ_EN_OFS)
                en_q <= (en_q & ~wm) | (wd & wm);
            if (we && ofs == GPIO_IRQ_EDGE_OFS)
                pol_q <= (pol_q & ~wm) | (wd & wm);
        end
    end

    assign irq = |(st_q & en_q);
    assign unused_bits = ^{addr[1:0], wr_data, mask32, IN_RESET};
`else
    assign irq = 1'b0;
    assign unused_bits = ^{addr[1:0], wr_data, mask32, IN_RESET, rise, fall};
`endif

    // read decode; unmapped and write-only offsets return zero
    always_comb begin
        rd_next = '0;
        case (ofs)
            GPIO_OUT_OFS:      rd_next = 32'(out_q);
            GPIO_OE_OFS:       rd_next = 32'(oe_q);
            GPIO_IN_OFS:       rd_next = 32'(in_sync);
`ifdef GPIO_IRQ_EN
            GPIO_IRQ_EN_OFS:   rd_next = 32'(en_q);
            GPIO_IRQ_STAT_OFS: rd_next = 32'(st_q);
            GPIO_IRQ_EDGE_OFS: rd_next = 32'(pol_q);
`endif
            default:           rd_next = '0;
        endcase
    end

    // registered read data, held while no read is issued
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rd_data <= '0;
        else if (re)
            rd_data <= rd_next;
    end

    assign gpio_out = out_q;
    assign gpio_oe  = oe_q;

endmodule
